// File: rtl/ahb_mtx_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_pkg
// Shared AHB bus-matrix definitions: HTRANS / HBURST encodings and the
// fixed-length burst beat count helper used by the output-stage arbiter.
// ---------------------------------------------------------------------------
package ahb_mtx_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Number of beats in a fixed-length burst. SINGLE and undefined-length
    // INCR report 1; INCR is held separately by the arbiter.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_mtx_rr_pick
// Combinational rotating-priority encoder. Searches req upward starting at
// last_grant+1 (wrapping modulo NUM_PORTS) and returns the first requester.
//
// Ports:
//   req        in  NUM_PORTS  per-port request vector
//   last_grant in  PORT_W     most recently granted port (< NUM_PORTS)
//   pick       out PORT_W     selected port (0 when no request)
//   any_req    out 1          at least one request present
// ---------------------------------------------------------------------------
module ahb_mtx_rr_pick
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic [PORT_W-1:0]    pick,
    output logic                 any_req
);

    // One extra bit so last_grant + i never overflows before the wrap.
    logic [PORT_W:0] cand;

    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        cand    = '0;
        // i = NUM_PORTS revisits last_grant itself, allowing a re-grant
        // when it is the only requester.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = {1'b0, last_grant} + (PORT_W+1)'(i);
            if (cand >= (PORT_W+1)'(NUM_PORTS)) begin
                cand = cand - (PORT_W+1)'(NUM_PORTS);
            end
            if (!any_req && req[cand[PORT_W-1:0]]) begin
                any_req = 1'b1;
                pick    = cand[PORT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_rr_arb.sv
// ---------------------------------------------------------------------------
// ahb_mtx_rr_arb
// Round-robin arbiter for a bus-matrix output stage. Chooses which input
// port owns the shared slave's address phase and holds that choice for the
// whole of a locked sequence or burst.
//
// Ports:
//   HCLK         in  1          AHB clock, rising edge
//   HRESET       in  1          asynchronous active-high reset
//   req_port     in  NUM_PORTS  per-port request (transfer AND HSEL)
//   HREADYM      in  1          output-stage HREADY; gates every update
//   HSELM        in  1          HSEL driven by the output stage
//   HTRANSM      in  2          HTRANS driven by the output stage
//   HBURSTM      in  3          HBURST driven by the output stage
//   HMASTLOCKM   in  1          masked HMASTLOCK
//   addr_in_port out PORT_W     registered granted port index
//   no_port      out 1          registered; 1 = no port granted
//
// Handshake: HREADYM acts as the ready of the address phase. The driven
// HTRANS/HBURST/HSEL are only meaningful on an edge where HREADYM=1; on
// any other edge every register holds its value.
// ---------------------------------------------------------------------------
module ahb_mtx_rr_arb
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    logic [PORT_W-1:0] addr_in_port_q, addr_in_port_d;
    logic              no_port_q,      no_port_d;
    logic [PORT_W-1:0] last_grant_q,   last_grant_d;
    logic [3:0]        beat_cnt_q,     beat_cnt_d;

    logic [3:0]        next_cnt;
    logic [4:0]        burst_len;
    logic              hold;
    logic [PORT_W-1:0] pick;
    logic              any_req;

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req        (req_port),
        .last_grant (last_grant_q),
        .pick       (pick),
        .any_req    (any_req)
    );

    assign burst_len = burst_beats(HBURSTM);

    // Beats remaining after the current address phase. Anything other than
    // a selected NONSEQ/SEQ/BUSY ends the burst early.
    always_comb begin
        next_cnt = 4'd0;
        if (HSELM) begin
            case (HTRANSM)
                HTRANS_NONSEQ: next_cnt = 4'(burst_len - 5'd1);
                HTRANS_SEQ:    next_cnt = (beat_cnt_q == 4'd0) ? 4'd0 : beat_cnt_q - 4'd1;
                HTRANS_BUSY:   next_cnt = beat_cnt_q;
                default:       next_cnt = 4'd0;
            endcase
        end
    end

    // Undefined-length INCR has no beat count, so it is held for as long
    // as the owner keeps driving a non-IDLE transfer to this slave.
    assign hold = HMASTLOCKM
                | (next_cnt != 4'd0)
                | (HSELM && (HBURSTM == HBURST_INCR) && (HTRANSM != HTRANS_IDLE));

    always_comb begin
        addr_in_port_d = addr_in_port_q;
        no_port_d      = no_port_q;
        last_grant_d   = last_grant_q;
        beat_cnt_d     = beat_cnt_q;
        if (HREADYM) begin
            beat_cnt_d = next_cnt;
            // A hold only protects an existing owner; with no_port set the
            // stage is idle and free to arbitrate.
            if (hold && !no_port_q) begin
                addr_in_port_d = addr_in_port_q;
            end else if (any_req) begin
                addr_in_port_d = pick;
                last_grant_d   = pick;
                no_port_d      = 1'b0;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_in_port_q <= '0;
            no_port_q      <= 1'b1;
            last_grant_q   <= LAST_PORT;
            beat_cnt_q     <= 4'd0;
        end else begin
            addr_in_port_q <= addr_in_port_d;
            no_port_q      <= no_port_d;
            last_grant_q   <= last_grant_d;
            beat_cnt_q     <= beat_cnt_d;
        end
    end

    assign addr_in_port = addr_in_port_q;
    assign no_port      = no_port_q;

endmodule
